alu_share_arbiter: RTL and testbench
====================================

Name: alu_share_arbiter

Overview:
- Shares one ALU32Bit instance between two requesters, such as the EX-stage datapath and a branch-compare/address helper.
- Arbitrates round-robin, registers the operands onto the ALU inputs and captures ALUResult/Zero.
- Returns the result to the granted requester over a valid/ready handshake.
- Sits between the requesters and the combinational ALU. Only one operation is in flight at a time.

Parameters:
DATA_W, 32, operand and result width
CTL_W, 6, ALU control code width (matches ALUControl)

Ports:
Clk  input  1  clock, all state on rising edge
Reset  input  1  synchronous, active-high reset
Req0Valid  input  1  requester 0 has an operation
Req0Ready  output  1  requester 0 operation accepted this cycle
Req0Ctl  input  CTL_W  ALU control code from requester 0
Req0A  input  DATA_W  operand A from requester 0
Req0B  input  DATA_W  operand B from requester 0
Req1Valid, Req1Ready, Req1Ctl, Req1A, Req1B  same directions/widths, requester 1
AluCtl  output  CTL_W  registered, drives ALUControl
AluA  output  DATA_W  registered, drives ALU A
AluB  output  DATA_W  registered, drives ALU B
AluResult  input  DATA_W  ALU result (combinational from AluA/AluB/AluCtl)
AluZero  input  1  ALU Zero flag
Rsp0Valid  output  1  result for requester 0 available
Rsp0Ready  input  1  requester 0 consumes result
Rsp0Result  output  DATA_W  captured result
Rsp0Zero  output  1  captured Zero
Rsp1Valid, Rsp1Ready, Rsp1Result, Rsp1Zero  same, requester 1
Busy  output  1  high whenever state != IDLE

Behaviour:
- Clock and reset: one clock, Clk. Reset is synchronous and active-high, sampled on the rising edge of Clk.
- Reset values:
  - State is IDLE and LastGrant = 1, so requester 0 wins the first contention.
  - AluCtl, AluA, AluB, Rsp0Result, Rsp1Result are 0.
  - Rsp0Zero, Rsp1Zero, Rsp0Valid, Rsp1Valid, Busy are 0.
- States are IDLE, EXEC and RESP.
- Grant (combinational, IDLE only):
  - Only one requester valid: that requester is granted.
  - Both valid: grant the requester != LastGrant.
  - ReqXReady = (state==IDLE) && ReqXValid && grant==X. Ready is never high outside IDLE and never high for both requesters.
- Accept edge (ReqXReady high):
  - AluCtl/AluA/AluB <= ReqXCtl/A/B.
  - Owner <= X, LastGrant <= X, state <= EXEC.
- EXEC (exactly 1 cycle):
  - ALU settles combinationally on the registered inputs.
  - At the edge: RspOwnerResult <= AluResult, RspOwnerZero <= AluZero, RspOwnerValid <= 1, state <= RESP.
- RESP:
  - RspOwnerValid stays high and Result/Zero stay stable until RspOwnerReady is high.
  - On that edge: RspOwnerValid <= 0 and state <= IDLE.
  - The non-owner RspValid is always 0.
- Latency and throughput:
  - Accept at edge N; RspValid is high in the cycle after edge N+1.
  - With Ready tied high the response is consumed at edge N+2, giving 3 cycles per operation.
  - No new grant is made while in EXEC or RESP.
- Operand hold: AluCtl/AluA/AluB hold their last values in IDLE and RESP and are not cleared. Rsp*Result keeps its last value after Valid drops.
- Width rules:
  - Result and Zero are passed through unmodified; the block does not decode ALUControl.
  - Any CTL_W code, including the branch codes, is forwarded as-is.
- Requester contract: ReqXValid, once asserted, holds with stable fields until ReqXReady. A Valid drop before grant is tolerated; the request is simply not served.
- Reset mid-operation (EXEC or RESP): the in-flight op is discarded, no response is issued, and all reset values apply on the next cycle.
- Fairness: under continuous contention, grants strictly alternate 0,1,0,1.

Test Plan:
- Reset, then Req0 Ctl=6'b100000 (add), A=5, B=3 -> Req0Ready in the first cycle; AluA=5/AluB=3 next cycle; Rsp0Valid=1, Rsp0Result=8, Rsp0Zero=0 one cycle later; Rsp1Valid stays 0.
- Req1 Ctl=6'b100010 (sub), A=7, B=7 -> Rsp1Result=0, Rsp1Zero=1, Rsp0Valid=0 throughout.
- Both requesters valid from reset with Rsp*Ready=1: Req0 add 1+1, Req1 or 0xF0|0x0F -> grant order 0,1; Rsp0Result=2, then Rsp1Result=0xFF; Req1Ready first high 3 cycles after Req0Ready.
- Continuous contention over 6 operations -> grant sequence 0,1,0,1,0,1; never two Ready high in the same cycle.
- Rsp0Ready held low 4 cycles after Rsp0Valid with Req1Valid=1 -> Rsp0Valid, Rsp0Result and Busy held stable; Req1Ready stays 0 until the cycle after Rsp0Ready rises.
- Reset asserted in EXEC of Req0 add 9+9 -> next cycle state IDLE, Rsp0Valid=0, AluA=0, Busy=0; no response for 18 ever appears; the next contention grants Req0 first.

Source files
------------

// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one combinational ALU between two requesters.
// Operands are registered onto the ALU, the result is captured and returned
// to the owner over a valid/ready handshake.

module alu_share_arbiter_chk (
    input logic Clk,
    input logic Reset,
    input logic Req0Ready,
    input logic Req1Ready,
    input logic Busy
);

    a_ready_onehot: assert property (@(posedge Clk) disable iff (Reset)
        !(Req0Ready && Req1Ready))
        else $error("both requesters ready in the same cycle");

    a_ready_idle_only: assert property (@(posedge Clk) disable iff (Reset)
        (Req0Ready || Req1Ready) |-> !Busy)
        else $error("ready asserted while busy");

endmodule

module alu_share_arbiter #(
    parameter int DATA_W = 32,
    parameter int CTL_W  = 6
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Req0Valid,
    output logic              Req0Ready,
    input  logic [CTL_W-1:0]  Req0Ctl,
    input  logic [DATA_W-1:0] Req0A,
    input  logic [DATA_W-1:0] Req0B,
    input  logic              Req1Valid,
    output logic              Req1Ready,
    input  logic [CTL_W-1:0]  Req1Ctl,
    input  logic [DATA_W-1:0] Req1A,
    input  logic [DATA_W-1:0] Req1B,
    output logic [CTL_W-1:0]  AluCtl,
    output logic [DATA_W-1:0] AluA,
    output logic [DATA_W-1:0] AluB,
    input  logic [DATA_W-1:0] AluResult,
    input  logic              AluZero,
    output logic              Rsp0Valid,
    input  logic              Rsp0Ready,
    output logic [DATA_W-1:0] Rsp0Result,
    output logic              Rsp0Zero,
    output logic              Rsp1Valid,
    input  logic              Rsp1Ready,
    output logic [DATA_W-1:0] Rsp1Result,
    output logic              Rsp1Zero,
    output logic              Busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t              state_r;
    logic                owner_r;
    logic                last_grant_r;
    logic [CTL_W-1:0]    alu_ctl_r;
    logic [DATA_W-1:0]   alu_a_r;
    logic [DATA_W-1:0]   alu_b_r;
    logic                rsp0_valid_r;
    logic [DATA_W-1:0]   rsp0_result_r;
    logic                rsp0_zero_r;
    logic                rsp1_valid_r;
    logic [DATA_W-1:0]   rsp1_result_r;
    logic                rsp1_zero_r;
    logic                busy_r;

    logic                grant_vld_s;
    logic                grant_s;
    logic                accept_s;
    logic                owner_ready_s;

    // Round-robin grant: on contention the requester that did not win last time goes next
    always_comb begin
        grant_vld_s = 1'b0;
        grant_s     = 1'b0;
        if (Req0Valid && Req1Valid) begin
            grant_vld_s = 1'b1;
            grant_s     = ~last_grant_r;
        end else if (Req0Valid) begin
            grant_vld_s = 1'b1;
            grant_s     = 1'b0;
        end else if (Req1Valid) begin
            grant_vld_s = 1'b1;
            grant_s     = 1'b1;
        end else begin
            grant_vld_s = 1'b0;
            grant_s     = 1'b0;
        end
    end

    // Acceptance and the owner's response-consume strobe
    always_comb begin
        accept_s      = (state_r == IDLE) && grant_vld_s;
        owner_ready_s = 1'b0;
        if (owner_r) begin
            owner_ready_s = Rsp1Ready;
        end else begin
            owner_ready_s = Rsp0Ready;
        end
    end

    assign Req0Ready = accept_s && (grant_s == 1'b0);
    assign Req1Ready = accept_s && (grant_s == 1'b1);

    // Arbitration FSM: operand load, result capture and response handshake
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_r       <= IDLE;
            owner_r       <= 1'b0;
            last_grant_r  <= 1'b1;
            alu_ctl_r     <= {CTL_W{1'b0}};
            alu_a_r       <= {DATA_W{1'b0}};
            alu_b_r       <= {DATA_W{1'b0}};
            rsp0_valid_r  <= 1'b0;
            rsp0_result_r <= {DATA_W{1'b0}};
            rsp0_zero_r   <= 1'b0;
            rsp1_valid_r  <= 1'b0;
            rsp1_result_r <= {DATA_W{1'b0}};
            rsp1_zero_r   <= 1'b0;
            busy_r        <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        if (grant_s) begin
                            alu_ctl_r <= Req1Ctl;
                            alu_a_r   <= Req1A;
                            alu_b_r   <= Req1B;
                        end else begin
                            alu_ctl_r <= Req0Ctl;
                            alu_a_r   <= Req0A;
                            alu_b_r   <= Req0B;
                        end
                        owner_r      <= grant_s;
                        last_grant_r <= grant_s;
                        state_r      <= EXEC;
                        busy_r       <= 1'b1;
                    end else begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                    end
                end
                // The ALU has had a full cycle to settle on the registered operands
                EXEC: begin
                    if (owner_r) begin
                        rsp1_result_r <= AluResult;
                        rsp1_zero_r   <= AluZero;
                        rsp1_valid_r  <= 1'b1;
                    end else begin
                        rsp0_result_r <= AluResult;
                        rsp0_zero_r   <= AluZero;
                        rsp0_valid_r  <= 1'b1;
                    end
                    state_r <= RESP;
                    busy_r  <= 1'b1;
                end
                RESP: begin
                    if (owner_ready_s) begin
                        rsp0_valid_r <= 1'b0;
                        rsp1_valid_r <= 1'b0;
                        state_r      <= IDLE;
                        busy_r       <= 1'b0;
                    end else begin
                        state_r <= RESP;
                        busy_r  <= 1'b1;
                    end
                end
                default: begin
                    rsp0_valid_r <= 1'b0;
                    rsp1_valid_r <= 1'b0;
                    state_r      <= IDLE;
                    busy_r       <= 1'b0;
                end
            endcase
        end
    end

    assign AluCtl     = alu_ctl_r;
    assign AluA       = alu_a_r;
    assign AluB       = alu_b_r;
    assign Rsp0Valid  = rsp0_valid_r;
    assign Rsp0Result = rsp0_result_r;
    assign Rsp0Zero   = rsp0_zero_r;
    assign Rsp1Valid  = rsp1_valid_r;
    assign Rsp1Result = rsp1_result_r;
    assign Rsp1Zero   = rsp1_zero_r;
    assign Busy       = busy_r;

    alu_share_arbiter_chk u_chk (
        .Clk       (Clk),
        .Reset     (Reset),
        .Req0Ready (Req0Ready),
        .Req1Ready (Req1Ready),
        .Busy      (Busy)
    );

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed, table-driven bench for alu_share_arbiter with a behavioural ALU
// attached to the registered operand outputs.

module tb_alu_share_arbiter;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        Req0Valid, Req1Valid;
    logic        Req0Ready, Req1Ready;
    logic [5:0]  Req0Ctl, Req1Ctl;
    logic [31:0] Req0A, Req0B, Req1A, Req1B;
    logic [5:0]  AluCtl;
    logic [31:0] AluA, AluB, AluResult;
    logic        AluZero;
    logic        Rsp0Valid, Rsp0Ready, Rsp0Zero;
    logic        Rsp1Valid, Rsp1Ready, Rsp1Zero;
    logic [31:0] Rsp0Result, Rsp1Result;
    logic        Busy;
    logic [31:0] alu_res;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 Clk = ~Clk;

    alu_share_arbiter #(.DATA_W(32), .CTL_W(6)) dut (
        .Clk(Clk), .Reset(Reset),
        .Req0Valid(Req0Valid), .Req0Ready(Req0Ready), .Req0Ctl(Req0Ctl), .Req0A(Req0A), .Req0B(Req0B),
        .Req1Valid(Req1Valid), .Req1Ready(Req1Ready), .Req1Ctl(Req1Ctl), .Req1A(Req1A), .Req1B(Req1B),
        .AluCtl(AluCtl), .AluA(AluA), .AluB(AluB), .AluResult(AluResult), .AluZero(AluZero),
        .Rsp0Valid(Rsp0Valid), .Rsp0Ready(Rsp0Ready), .Rsp0Result(Rsp0Result), .Rsp0Zero(Rsp0Zero),
        .Rsp1Valid(Rsp1Valid), .Rsp1Ready(Rsp1Ready), .Rsp1Result(Rsp1Result), .Rsp1Zero(Rsp1Zero),
        .Busy(Busy)
    );

    // Behavioural ALU32Bit subset; unknown codes fall back to XOR
    always_comb begin
        case (AluCtl)
            6'b100000: alu_res = AluA + AluB;
            6'b100010: alu_res = AluA - AluB;
            6'b100100: alu_res = AluA & AluB;
            6'b100101: alu_res = AluA | AluB;
            default:   alu_res = AluA ^ AluB;
        endcase
    end
    assign AluResult = alu_res;
    assign AluZero   = (alu_res == 32'd0);

    typedef struct {
        logic        req;
        logic [5:0]  ctl;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        zero;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        Req0Valid = 1'b0;
        Req1Valid = 1'b0;
        tick();
        tick();
        Reset = 1'b0;
    endtask

    initial begin
        int ng, nr0, nr1;
        logic [0:0] grants[6];
        int cycs[6];

        vecs[0] = '{1'b0, 6'b100000, 32'd5,          32'd3,          32'd8,          1'b0};
        vecs[1] = '{1'b1, 6'b100010, 32'd7,          32'd7,          32'd0,          1'b1};
        vecs[2] = '{1'b1, 6'b100101, 32'h000000F0,   32'h0000000F,   32'h000000FF,   1'b0};
        vecs[3] = '{1'b0, 6'b100100, 32'h0000F0F0,   32'h00000F0F,   32'd0,          1'b1};
        vecs[4] = '{1'b0, 6'b100010, 32'd3,          32'd5,          32'hFFFFFFFE,   1'b0};
        vecs[5] = '{1'b1, 6'b000100, 32'hA5A5A5A5,   32'hA5A5A5A5,   32'd0,          1'b1};
        vecs[6] = '{1'b1, 6'b100000, 32'hFFFFFFFF,   32'd1,          32'd0,          1'b1};

        Req0Ctl = 6'd0; Req0A = 32'd0; Req0B = 32'd0;
        Req1Ctl = 6'd0; Req1A = 32'd0; Req1B = 32'd0;
        Rsp0Ready = 1'b1;
        Rsp1Ready = 1'b1;
        do_reset();
        #1;
        chk("rst_aluctl", {26'd0, AluCtl}, 32'd0);
        chk("rst_alua", AluA, 32'd0);
        chk("rst_alub", AluB, 32'd0);
        chk("rst_rsp0v", {31'd0, Rsp0Valid}, 32'd0);
        chk("rst_rsp1v", {31'd0, Rsp1Valid}, 32'd0);
        chk("rst_rsp0r", Rsp0Result, 32'd0);
        chk("rst_rsp1r", Rsp1Result, 32'd0);
        chk("rst_zeros", {30'd0, Rsp0Zero, Rsp1Zero}, 32'd0);
        chk("rst_busy", {31'd0, Busy}, 32'd0);

        // Single operations through each requester, ready tied high
        for (int i = 0; i < 7; i++) begin
            if (vecs[i].req) begin
                Req1Ctl = vecs[i].ctl; Req1A = vecs[i].a; Req1B = vecs[i].b; Req1Valid = 1'b1;
            end else begin
                Req0Ctl = vecs[i].ctl; Req0A = vecs[i].a; Req0B = vecs[i].b; Req0Valid = 1'b1;
            end
            #1;
            chk($sformatf("v%0d_ready", i), {30'd0, Req1Ready, Req0Ready},
                vecs[i].req ? 32'd2 : 32'd1);
            tick();
            Req0Valid = 1'b0;
            Req1Valid = 1'b0;
            #1;
            chk($sformatf("v%0d_aluctl", i), {26'd0, AluCtl}, {26'd0, vecs[i].ctl});
            chk($sformatf("v%0d_alua", i), AluA, vecs[i].a);
            chk($sformatf("v%0d_alub", i), AluB, vecs[i].b);
            chk($sformatf("v%0d_busy_exec", i), {31'd0, Busy}, 32'd1);
            chk($sformatf("v%0d_exec_rspv", i), {30'd0, Rsp1Valid, Rsp0Valid}, 32'd0);
            tick();
            chk($sformatf("v%0d_rspv", i), {30'd0, Rsp1Valid, Rsp0Valid},
                vecs[i].req ? 32'd2 : 32'd1);
            chk($sformatf("v%0d_result", i), vecs[i].req ? Rsp1Result : Rsp0Result, vecs[i].res);
            chk($sformatf("v%0d_zero", i), {31'd0, vecs[i].req ? Rsp1Zero : Rsp0Zero},
                {31'd0, vecs[i].zero});
            tick();
            chk($sformatf("v%0d_idle_rspv", i), {30'd0, Rsp1Valid, Rsp0Valid}, 32'd0);
            chk($sformatf("v%0d_idle_busy", i), {31'd0, Busy}, 32'd0);
            chk($sformatf("v%0d_hold_result", i), vecs[i].req ? Rsp1Result : Rsp0Result, vecs[i].res);
            chk($sformatf("v%0d_hold_alua", i), AluA, vecs[i].a);
        end

        // Continuous contention from reset: grants alternate starting with requester 0
        do_reset();
        Req0Ctl = 6'b100000; Req0A = 32'd1;   Req0B = 32'd1;
        Req1Ctl = 6'b100101; Req1A = 32'hF0;  Req1B = 32'h0F;
        Req0Valid = 1'b1;
        Req1Valid = 1'b1;
        #1;
        ng = 0; nr0 = 0; nr1 = 0;
        for (int c = 0; c < 18; c++) begin
            if (Req0Ready && Req1Ready) chk("both_ready", 32'd1, 32'd0);
            if ((Req0Ready || Req1Ready) && ng < 6) begin
                grants[ng] = Req1Ready;
                cycs[ng] = c;
                ng++;
            end
            if (Rsp0Valid) begin
                nr0++;
                chk("cont_rsp0", Rsp0Result, 32'd2);
            end
            if (Rsp1Valid) begin
                nr1++;
                chk("cont_rsp1", Rsp1Result, 32'hFF);
            end
            tick();
        end
        Req0Valid = 1'b0;
        Req1Valid = 1'b0;
        chk("cont_ngrants", ng, 32'd6);
        for (int g = 0; g < 6; g++)
            chk($sformatf("cont_grant%0d", g), {31'd0, grants[g]}, g % 2);
        chk("cont_gap", cycs[1] - cycs[0], 32'd3);
        chk("cont_nrsp0", nr0, 32'd3);
        chk("cont_nrsp1", nr1, 32'd3);

        // Backpressure on response 0 with requester 1 waiting
        do_reset();
        Rsp0Ready = 1'b0;
        Req0Ctl = 6'b100000; Req0A = 32'd2;  Req0B = 32'd2;
        Req1Ctl = 6'b100000; Req1A = 32'd10; Req1B = 32'd20;
        Req0Valid = 1'b1;
        #1;
        chk("bp_ready0", {31'd0, Req0Ready}, 32'd1);
        tick();
        Req0Valid = 1'b0;
        Req1Valid = 1'b1;
        #1;
        chk("bp_exec_ready1", {31'd0, Req1Ready}, 32'd0);
        tick();
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("bp%0d_rsp0v", k), {31'd0, Rsp0Valid}, 32'd1);
            chk($sformatf("bp%0d_rsp0r", k), Rsp0Result, 32'd4);
            chk($sformatf("bp%0d_busy", k), {31'd0, Busy}, 32'd1);
            chk($sformatf("bp%0d_ready1", k), {31'd0, Req1Ready}, 32'd0);
            tick();
        end
        Rsp0Ready = 1'b1;
        #1;
        chk("bp_rise_ready1", {31'd0, Req1Ready}, 32'd0);
        chk("bp_rise_rsp0v", {31'd0, Rsp0Valid}, 32'd1);
        tick();
        chk("bp_after_rsp0v", {31'd0, Rsp0Valid}, 32'd0);
        chk("bp_after_ready1", {31'd0, Req1Ready}, 32'd1);
        chk("bp_after_rsp0r", Rsp0Result, 32'd4);
        tick();
        Req1Valid = 1'b0;
        tick();
        chk("bp_rsp1v", {31'd0, Rsp1Valid}, 32'd1);
        chk("bp_rsp1r", Rsp1Result, 32'd30);
        chk("bp_rsp0v_quiet", {31'd0, Rsp0Valid}, 32'd0);
        tick();

        // Reset while the operation is executing
        do_reset();
        Req0Ctl = 6'b100000; Req0A = 32'd9; Req0B = 32'd9;
        Req0Valid = 1'b1;
        #1;
        chk("rx_ready0", {31'd0, Req0Ready}, 32'd1);
        tick();
        Req0Valid = 1'b0;
        #1;
        chk("rx_exec_alua", AluA, 32'd9);
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        chk("rx_rsp0v", {31'd0, Rsp0Valid}, 32'd0);
        chk("rx_alua", AluA, 32'd0);
        chk("rx_busy", {31'd0, Busy}, 32'd0);
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("rx%0d_no_rsp", k), {31'd0, Rsp0Valid}, 32'd0);
            chk($sformatf("rx%0d_no_18", k), Rsp0Result, 32'd0);
            tick();
        end
        Req0Valid = 1'b1;
        Req1Valid = 1'b1;
        #1;
        chk("rx_first_grant", {30'd0, Req1Ready, Req0Ready}, 32'd1);
        Req0Valid = 1'b0;
        Req1Valid = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
